// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LDR  = 1'b1;

  localparam int unsigned MEM_LAT_MAX = 4;
  localparam int unsigned CNT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin picker: on a tie the requester not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == REQ_LDR) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the core and the program loader,
// routing each read response back to the requester that issued it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       req_vec, arb_gnt;
  logic             last_gnt, owner, win, win_we, issue, capture;

  assign req_vec = {ldr_req, core_req};
  assign win     = arb_gnt[1];
  assign win_we  = win ? ldr_we : core_we;
  assign busy    = (state == RD_WAIT);

  rr_arb2 u_arb (
    .req  (req_vec),
    .last (last_gnt),
    .gnt  (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Issue, memory mux and read-latency countdown.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    issue      = 1'b0;
    capture    = 1'b0;
    core_gnt   = 1'b0;
    ldr_gnt    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (!reset && (|req_vec)) begin
          issue     = 1'b1;
          core_gnt  = arb_gnt[0];
          ldr_gnt   = arb_gnt[1];
          mem_en    = 1'b1;
          mem_we    = win_we;
          mem_addr  = win ? ldr_addr  : core_addr;
          mem_wdata = win ? ldr_wdata : core_wdata;
          if (!win_we) begin
            state_next = RD_WAIT;
            cnt_next   = CNT_W'(MEM_LAT);
          end
        end
      end
      RD_WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointer, owner and per-requester response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      owner       <= REQ_CORE;
      last_gnt    <= REQ_LDR;
      core_rvalid <= 1'b0;
      ldr_rvalid  <= 1'b0;
      core_rdata  <= '0;
      ldr_rdata   <= '0;
    end else begin
      cnt         <= cnt_next;
      core_rvalid <= capture && (owner == REQ_CORE);
      ldr_rvalid  <= capture && (owner == REQ_LDR);
      if (issue) last_gnt <= win;
      if (issue && !win_we) owner <= win;
      if (capture && (owner == REQ_CORE)) core_rdata <= mem_rdata;
      if (capture && (owner == REQ_LDR))  ldr_rdata  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter at MEM_LAT=1 (u0) and MEM_LAT=3 (u1).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_s   [2][2];
  logic        we_s    [2][2];
  logic [31:0] addr_s  [2][2];
  logic [31:0] wdata_s [2][2];
  logic        gnt_o   [2][2];
  logic        rv_o    [2][2];
  logic [31:0] rd_o    [2][2];
  logic        mem_en_o [2];
  logic        mem_we_o [2];
  logic [31:0] mem_addr_o  [2];
  logic [31:0] mem_wdata_o [2];
  logic [31:0] mem_rdata_s [2];
  logic        busy_o [2];

  int          cyc, tests, fails;
  bit          chk_en, rand_mode, auto_rd;
  int          free_at [2];
  int          rv_cyc  [2];
  int          gwin    [2];
  bit          pend    [2];
  bit          last    [2];
  bit          rv_who  [2];
  logic [31:0] rv_dat  [2];
  logic [31:0] exp_rd  [2][2];
  logic [31:0] mem     [2][16];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u0 (
    .clk(clk), .reset(reset),
    .core_req(req_s[0][0]), .core_we(we_s[0][0]), .core_addr(addr_s[0][0]), .core_wdata(wdata_s[0][0]),
    .core_gnt(gnt_o[0][0]), .core_rvalid(rv_o[0][0]), .core_rdata(rd_o[0][0]),
    .ldr_req(req_s[0][1]), .ldr_we(we_s[0][1]), .ldr_addr(addr_s[0][1]), .ldr_wdata(wdata_s[0][1]),
    .ldr_gnt(gnt_o[0][1]), .ldr_rvalid(rv_o[0][1]), .ldr_rdata(rd_o[0][1]),
    .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]),
    .mem_rdata(mem_rdata_s[0]), .busy(busy_o[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u1 (
    .clk(clk), .reset(reset),
    .core_req(req_s[1][0]), .core_we(we_s[1][0]), .core_addr(addr_s[1][0]), .core_wdata(wdata_s[1][0]),
    .core_gnt(gnt_o[1][0]), .core_rvalid(rv_o[1][0]), .core_rdata(rd_o[1][0]),
    .ldr_req(req_s[1][1]), .ldr_we(we_s[1][1]), .ldr_addr(addr_s[1][1]), .ldr_wdata(wdata_s[1][1]),
    .ldr_gnt(gnt_o[1][1]), .ldr_rvalid(rv_o[1][1]), .ldr_rdata(rd_o[1][1]),
    .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]),
    .mem_rdata(mem_rdata_s[1]), .busy(busy_o[1])
  );

  task automatic check(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s[u%0d] cyc=%0d observed=%h expected=%h", tag, inst, cyc, got, exp);
    end
  endtask

  task automatic new_req(input int i, input int w, input bit we);
    req_s[i][w]   = 1'b1;
    we_s[i][w]    = we;
    addr_s[i][w]  = 32'($urandom_range(0, 15)) << 2;
    wdata_s[i][w] = $urandom;
  endtask

  // Reference: one access at a time; a read blocks arbitration until its data returns.
  task automatic model_check(input int i);
    int          g, lat;
    bit          een, ewe, rvnow;
    logic [31:0] ea, ewd;
    lat   = (i == 0) ? 1 : 3;
    rvnow = pend[i] && (rv_cyc[i] == cyc);
    if (rvnow) exp_rd[i][rv_who[i]] = rv_dat[i];
    g = -1;
    if (!reset && cyc >= free_at[i]) begin
      if (req_s[i][0] && req_s[i][1]) g = last[i] ? 0 : 1;
      else if (req_s[i][0])           g = 0;
      else if (req_s[i][1])           g = 1;
    end
    een = (g >= 0);
    ewe = een ? we_s[i][g] : 1'b0;
    ea  = een ? addr_s[i][g] : 32'h0;
    ewd = een ? wdata_s[i][g] : 32'h0;
    if (chk_en) begin
      check("core_gnt",    i, 32'(gnt_o[i][0]), 32'(g == 0));
      check("ldr_gnt",     i, 32'(gnt_o[i][1]), 32'(g == 1));
      check("mem_en",      i, 32'(mem_en_o[i]), 32'(een));
      check("mem_we",      i, 32'(mem_we_o[i]), 32'(ewe));
      check("mem_addr",    i, mem_addr_o[i], ea);
      check("mem_wdata",   i, mem_wdata_o[i], ewd);
      check("core_rvalid", i, 32'(rv_o[i][0]), 32'(rvnow && rv_who[i] == 1'b0));
      check("ldr_rvalid",  i, 32'(rv_o[i][1]), 32'(rvnow && rv_who[i] == 1'b1));
      check("core_rdata",  i, rd_o[i][0], exp_rd[i][0]);
      check("ldr_rdata",   i, rd_o[i][1], exp_rd[i][1]);
      check("busy",        i, 32'(busy_o[i]), 32'(cyc < free_at[i]));
    end
    if (rvnow) pend[i] = 1'b0;
    if (een) begin
      last[i] = (g == 1);
      if (ewe) mem[i][ea[5:2]] = ewd;
      else begin
        pend[i]    = 1'b1;
        rv_cyc[i]  = cyc + lat + 1;
        rv_who[i]  = (g == 1);
        rv_dat[i]  = mem[i][ea[5:2]];
        free_at[i] = cyc + lat + 1;
      end
    end
    if (reset) begin
      last[i]      = 1'b1;
      pend[i]      = 1'b0;
      free_at[i]   = cyc + 1;
      exp_rd[i][0] = 32'h0;
      exp_rd[i][1] = 32'h0;
    end
    gwin[i] = g;
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_check(i);
    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) reset = ($urandom_range(0, 63) == 0);
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 2; w++) begin
        if (gwin[i] == w) begin
          req_s[i][w] = 1'b0;
          if (auto_rd) new_req(i, w, 1'b0);
        end
        if (rand_mode && !req_s[i][w] && $urandom_range(0, 2) != 0)
          new_req(i, w, $urandom_range(0, 2) == 0);
      end
      mem_rdata_s[i] = (pend[i] && cyc == rv_cyc[i] - 1) ? rv_dat[i] : $urandom;
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    chk_en = 1'b0; rand_mode = 1'b0; auto_rd = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      free_at[i] = 0; rv_cyc[i] = 0; gwin[i] = -1; pend[i] = 1'b0; last[i] = 1'b1;
      rv_who[i] = 1'b0; rv_dat[i] = 32'h0; mem_rdata_s[i] = $urandom;
      for (int w = 0; w < 2; w++) begin
        req_s[i][w] = 1'b0; we_s[i][w] = 1'b0; addr_s[i][w] = 32'h0; wdata_s[i][w] = 32'h0;
        exp_rd[i][w] = 32'h0;
      end
      for (int k = 0; k < 16; k++) mem[i][k] = $urandom;
    end
    step();
    chk_en = 1'b1;
    step();
    step();

    // Core read of 0x10 straight out of reset.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem[i][4] = 32'hDEADBEEF;
      req_s[i][0] = 1'b1; we_s[i][0] = 1'b0; addr_s[i][0] = 32'h10; wdata_s[i][0] = 32'h0;
    end
    #1;
    check("t1_gnt", 0, 32'(gnt_o[0][0]), 32'h1);
    check("t1_addr", 0, mem_addr_o[0], 32'h10);
    step();
    step();
    check("t1_rvalid", 0, 32'(rv_o[0][0]), 32'h1);
    check("t1_rdata", 0, rd_o[0][0], 32'hDEADBEEF);
    check("t1_ldr_rvalid", 0, 32'(rv_o[0][1]), 32'h0);
    check("t1_ldr_rdata", 0, rd_o[0][1], 32'h0);
    repeat (4) step();

    // Continuous contention from reset: core first, then alternating.
    reset = 1'b1;
    step();
    reset = 1'b0;
    auto_rd = 1'b1;
    for (int i = 0; i < 2; i++) begin
      new_req(i, 0, 1'b0);
      new_req(i, 1, 1'b0);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check("t2_core_first", i, 32'(gnt_o[i][0]), 32'h1);
      check("t2_ldr_wait", i, 32'(gnt_o[i][1]), 32'h0);
    end
    repeat (24) step();
    auto_rd = 1'b0;
    repeat (12) step();

    // Back-to-back loader writes.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin
        req_s[i][1] = 1'b1; we_s[i][1] = 1'b1; addr_s[i][1] = 32'(k * 4); wdata_s[i][1] = 32'h13;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        check("t3_we", i, 32'(mem_we_o[i]), 32'h1);
        check("t3_addr", i, mem_addr_o[i], 32'(k * 4));
      end
      step();
    end
    step();

    // Loader write held off while a core read is outstanding.
    for (int i = 0; i < 2; i++) begin
      req_s[i][0] = 1'b1; we_s[i][0] = 1'b0; addr_s[i][0] = 32'h20;
    end
    step();
    for (int i = 0; i < 2; i++) begin
      req_s[i][1] = 1'b1; we_s[i][1] = 1'b1; addr_s[i][1] = 32'h24; wdata_s[i][1] = $urandom;
    end
    for (int k = 1; k <= 3; k++) begin
      #1;
      check("t4_ldr_held", 1, 32'(gnt_o[1][1]), 32'h0);
      step();
    end
    #1;
    check("t4_core_rvalid", 1, 32'(rv_o[1][0]), 32'h1);
    check("t4_ldr_gnt", 1, 32'(gnt_o[1][1]), 32'h1);
    repeat (4) step();

    // Reset one cycle after a read grant.
    for (int i = 0; i < 2; i++) begin
      req_s[i][0] = 1'b1; we_s[i][0] = 1'b0; addr_s[i][0] = 32'h30;
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_s[i][0] = 1'b0;
      req_s[i][1] = 1'b1; we_s[i][1] = 1'b0; addr_s[i][1] = 32'h34;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check("t5_gnt", i, 32'(gnt_o[i][1]), 32'h1);
      check("t5_rvalid", i, 32'(rv_o[i][0]), 32'h0);
      check("t5_rdata", i, rd_o[i][0], 32'h0);
      check("t5_busy", i, 32'(busy_o[i]), 32'h0);
    end
    repeat (6) step();

    // Random traffic with occasional resets.
    rand_mode = 1'b1;
    repeat (800) step();
    rand_mode = 1'b0;
    reset = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
